// File: rtl/morse_pkg.sv
// morse_pkg: constants shared by the alphabet decoder, the text buffer and
// the VGA renderer.
//   LETTER_W     - width of a decoded letter code
//   LETTER_BLANK - code the display paths render as an empty cell
//   letter_e     - letter codes, A = 0 .. Z = 25
package morse_pkg;

   localparam int LETTER_W = 5;

   typedef logic [LETTER_W-1:0] letter_t;

   localparam letter_t LETTER_BLANK = 5'd31;

   typedef enum logic [LETTER_W-1:0] {
      L_A, L_B, L_C, L_D, L_E, L_F, L_G, L_H, L_I, L_J, L_K, L_L, L_M,
      L_N, L_O, L_P, L_Q, L_R, L_S, L_T, L_U, L_V, L_W, L_X, L_Y, L_Z
   } letter_e;

endpackage

// File: rtl/morse_text_buffer_if.sv
// morse_text_buffer_if: letter input, edit controls and read port of the
// text buffer.
//   master - decoder/display side: drives LETTER, STROBE, BACKSPACE, CLEAR,
//            RD_IDX; observes read data and status
//   slave  - the buffer itself
interface morse_text_buffer_if #(
   parameter int AW = 4
);
   import morse_pkg::*;

   letter_t          LETTER;
   logic             STROBE;
   logic             BACKSPACE;
   logic             CLEAR;
   logic [AW-1:0]    RD_IDX;
   letter_t          RD_LETTER;
   logic             RD_VALID;
   logic [AW:0]      COUNT;
   logic             EMPTY;
   logic             FULL;
   logic             OVERFLOW;
   logic             NEW_LETTER;

   modport master (
      output LETTER, STROBE, BACKSPACE, CLEAR, RD_IDX,
      input  RD_LETTER, RD_VALID, COUNT, EMPTY, FULL, OVERFLOW, NEW_LETTER
   );

   modport slave (
      input  LETTER, STROBE, BACKSPACE, CLEAR, RD_IDX,
      output RD_LETTER, RD_VALID, COUNT, EMPTY, FULL, OVERFLOW, NEW_LETTER
   );

endinterface

// File: rtl/morse_text_buffer_edge_pulse.sv
// edge_pulse: single-bit rising-edge detector.
//   clk, rst_n - clock, asynchronous active-low reset
//   din        - level input (already synchronous / debounced)
//   pulse      - combinational, high in the cycle din is first seen high
module edge_pulse (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic pulse
);

   logic din_q;
   logic armed;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         din_q <= 1'b0;
         armed <= 1'b0;
      end else begin
         din_q <= din;
         armed <= 1'b1;
      end
   end

   // History resets to 0, so without 'armed' a level held high through reset
   // release would look like a fresh edge. The first clock after release
   // only loads the history; detection starts on the second.
   assign pulse = armed & din & ~din_q;

endmodule

// File: rtl/morse_text_buffer.sv
// morse_text_buffer: circular buffer of decoded letters, oldest to newest,
// with backspace, clear and a registered random-read port for the displays.
//   CLK, RESET_N - clock, asynchronous active-low reset
//   bus          - slave side of morse_text_buffer_if:
//                  LETTER/STROBE commit, BACKSPACE, CLEAR (rising-edge events),
//                  RD_IDX -> RD_LETTER/RD_VALID (1-cycle latency),
//                  COUNT/EMPTY/FULL/OVERFLOW status, NEW_LETTER pulse
// DEPTH must be a power of two >= 2 and AW = log2(DEPTH).
module morse_text_buffer
   import morse_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input logic                CLK,
   input logic                RESET_N,
   morse_text_buffer_if.slave bus
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic stb_ev, bs_ev, clr_ev;

   edge_pulse u_stb (.clk(CLK), .rst_n(RESET_N), .din(bus.STROBE),    .pulse(stb_ev));
   edge_pulse u_bs  (.clk(CLK), .rst_n(RESET_N), .din(bus.BACKSPACE), .pulse(bs_ev));
   edge_pulse u_clr (.clk(CLK), .rst_n(RESET_N), .din(bus.CLEAR),     .pulse(clr_ev));

   letter_t        mem [DEPTH];

   logic [AW-1:0]  head, tail, head_n, tail_n;
   logic [AW:0]    count, count_n;
   logic           empty, full, ovf, ovf_n;
   logic           new_letter, new_letter_n;
   logic           we;
   logic [AW-1:0]  waddr;
   logic [AW-1:0]  raddr;
   logic           rd_hit;
   letter_t        rd_letter;
   logic           rd_valid;

   // Event resolution: clear wins outright; strobe+backspace on a non-empty
   // buffer replaces the newest letter in place.
   always_comb begin
      head_n       = head;
      tail_n       = tail;
      count_n      = count;
      ovf_n        = ovf;
      new_letter_n = 1'b0;
      we           = 1'b0;
      waddr        = tail;
      if (clr_ev) begin
         head_n  = '0;
         tail_n  = '0;
         count_n = '0;
         ovf_n   = 1'b0;
      end else if (stb_ev && bs_ev && !empty) begin
         we           = 1'b1;
         waddr        = tail - 1'b1;
         new_letter_n = 1'b1;
      end else if (stb_ev) begin
         we           = 1'b1;
         waddr        = tail;
         tail_n       = tail + 1'b1;
         new_letter_n = 1'b1;
         if (full) begin
            // oldest letter is overwritten
            head_n = head + 1'b1;
            ovf_n  = 1'b1;
         end else begin
            count_n = count + 1'b1;
         end
      end else if (bs_ev && !empty) begin
         tail_n  = tail - 1'b1;
         count_n = count - 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         empty      <= 1'b1;
         full       <= 1'b0;
         ovf        <= 1'b0;
         new_letter <= 1'b0;
      end else begin
         head       <= head_n;
         tail       <= tail_n;
         count      <= count_n;
         // flags come from the same next-count so they never disagree with COUNT
         empty      <= (count_n == '0);
         full       <= (count_n == FULL_CNT);
         ovf        <= ovf_n;
         new_letter <= new_letter_n;
      end
   end

   // Storage carries no reset; only slots below COUNT are ever exposed.
   always_ff @(posedge CLK) begin
      if (we) mem[waddr] <= bus.LETTER;
   end

   // Read port: logical index is relative to head; mem is sampled before the
   // same-edge write lands, giving read-before-write.
   assign raddr  = head + bus.RD_IDX;
   assign rd_hit = ({1'b0, bus.RD_IDX} < count);

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         rd_letter <= LETTER_BLANK;
         rd_valid  <= 1'b0;
      end else begin
         rd_letter <= rd_hit ? mem[raddr] : LETTER_BLANK;
         rd_valid  <= rd_hit;
      end
   end

   assign bus.RD_LETTER  = rd_letter;
   assign bus.RD_VALID   = rd_valid;
   assign bus.COUNT      = count;
   assign bus.EMPTY      = empty;
   assign bus.FULL       = full;
   assign bus.OVERFLOW   = ovf;
   assign bus.NEW_LETTER = new_letter;

endmodule

// File: tb/tb_morse_text_buffer.sv
module tb_morse_text_buffer;
   import morse_pkg::*;

   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic clk;
   logic rst_n;

   morse_text_buffer_if #(.AW(AW)) bus ();

   morse_text_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
      .CLK     (clk),
      .RESET_N (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int nl_cnt = 0;
   int nl0;

   // reference model: letters oldest..newest plus sticky overflow
   int model_q [$];
   bit model_ovf;

   typedef struct {
      int letter;
      int valid;
   } rd_exp_t;
   rd_exp_t sb [$];

   // NEW_LETTER sampled just before each edge so a 1-cycle pulse counts once
   always @(posedge clk) if (rst_n && bus.NEW_LETTER) nl_cnt++;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic m_ev(input bit stb, input bit bs, input bit clr, input int l);
      if (clr) begin
         model_q.delete();
         model_ovf = 1'b0;
      end else if (stb && bs && model_q.size() > 0) begin
         model_q[model_q.size()-1] = l;
      end else if (stb) begin
         if (model_q.size() == DEPTH) begin
            void'(model_q.pop_front());
            model_ovf = 1'b1;
         end
         model_q.push_back(l);
      end else if (bs && model_q.size() > 0) begin
         void'(model_q.pop_back());
      end
   endtask

   // one-cycle pulse on the selected inputs, then one idle cycle
   task automatic ev(input bit stb, input bit bs, input bit clr, input int l);
      bus.LETTER    = letter_t'(l);
      bus.STROBE    = stb;
      bus.BACKSPACE = bs;
      bus.CLEAR     = clr;
      @(negedge clk);
      m_ev(stb, bs, clr, l);
      bus.STROBE    = 1'b0;
      bus.BACKSPACE = 1'b0;
      bus.CLEAR     = 1'b0;
      @(negedge clk);
   endtask

   task automatic rd(input int idx);
      rd_exp_t e, g;
      bus.RD_IDX = AW'(idx);
      e.valid  = (idx < model_q.size()) ? 1 : 0;
      e.letter = e.valid ? model_q[idx] : 31;
      sb.push_back(e);
      @(negedge clk);
      g = sb.pop_front();
      chk($sformatf("rd%0d_letter", idx), int'(bus.RD_LETTER), g.letter);
      chk($sformatf("rd%0d_valid", idx), int'(bus.RD_VALID), g.valid);
   endtask

   task automatic chk_state(input string tag);
      chk({tag, "_count"}, int'(bus.COUNT), model_q.size());
      chk({tag, "_empty"}, int'(bus.EMPTY), (model_q.size() == 0) ? 1 : 0);
      chk({tag, "_full"},  int'(bus.FULL),  (model_q.size() == DEPTH) ? 1 : 0);
      chk({tag, "_ovf"},   int'(bus.OVERFLOW), int'(model_ovf));
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_count"}, int'(bus.COUNT), 0);
      chk({tag, "_empty"}, int'(bus.EMPTY), 1);
      chk({tag, "_full"},  int'(bus.FULL), 0);
      chk({tag, "_ovf"},   int'(bus.OVERFLOW), 0);
      chk({tag, "_nl"},    int'(bus.NEW_LETTER), 0);
      chk({tag, "_rdl"},   int'(bus.RD_LETTER), 31);
      chk({tag, "_rdv"},   int'(bus.RD_VALID), 0);
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.LETTER    = '0;
      bus.STROBE    = 1'b0;
      bus.BACKSPACE = 1'b0;
      bus.CLEAR     = 1'b0;
      bus.RD_IDX    = '0;
      model_ovf     = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_outs("por");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // C A T
      nl0 = nl_cnt;
      ev(1, 0, 0, 2);
      ev(1, 0, 0, 0);
      ev(1, 0, 0, 19);
      chk_state("cat");
      chk("cat_nl", nl_cnt - nl0, 3);
      for (int i = 0; i < 4; i++) rd(i);

      // backspace down to empty and past it
      ev(0, 1, 0, 0);
      chk_state("bs1");
      repeat (3) ev(0, 1, 0, 0);
      chk_state("bs_empty");
      ev(1, 0, 0, 7);
      chk_state("bs_after");
      rd(0);
      rd(1);

      // held strobe commits once
      ev(0, 0, 1, 0);
      nl0 = nl_cnt;
      bus.LETTER = 5'd4;
      bus.STROBE = 1'b1;
      repeat (10) @(negedge clk);
      m_ev(1, 0, 0, 4);
      bus.STROBE = 1'b0;
      @(negedge clk);
      chk_state("hold");
      chk("hold_nl", nl_cnt - nl0, 1);
      rd(0);

      // overflow: 17 letters into 16 slots
      ev(0, 0, 1, 0);
      for (int i = 0; i < 17; i++) ev(1, 0, 0, i);
      chk_state("ovf");
      rd(0);
      rd(15);
      rd(7);

      // clear beats a same-cycle strobe
      ev(1, 0, 1, 9);
      chk_state("clr_stb");
      rd(0);

      // strobe + backspace replaces newest
      ev(1, 0, 0, 3);
      ev(1, 0, 0, 5);
      nl0 = nl_cnt;
      ev(1, 1, 0, 25);
      chk_state("repl");
      chk("repl_nl", nl_cnt - nl0, 1);
      rd(0);
      rd(1);
      rd(2);

      // strobe + backspace on empty buffer is a plain commit
      ev(0, 0, 1, 0);
      ev(1, 1, 0, 12);
      chk_state("repl_empty");
      rd(0);

      // async reset mid-commit with FULL and OVERFLOW set
      for (int i = 0; i < 17; i++) ev(1, 0, 0, 20 - i);
      chk_state("pre_rst");
      bus.LETTER    = 5'd30;
      bus.STROBE    = 1'b1;
      bus.BACKSPACE = 1'b1;
      #2 rst_n = 1'b0;
      #1 chk_reset_outs("async_rst");
      m_ev(0, 0, 1, 0);
      sb.delete();
      repeat (2) @(negedge clk);
      nl0 = nl_cnt;
      #2 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk_state("held_release");
      chk("held_release_nl", nl_cnt - nl0, 0);
      bus.STROBE = 1'b0;
      @(negedge clk);
      // backspace still held: a fresh strobe must survive
      bus.LETTER = 5'd9;
      bus.STROBE = 1'b1;
      @(negedge clk);
      m_ev(1, 0, 0, 9);
      bus.STROBE = 1'b0;
      @(negedge clk);
      bus.BACKSPACE = 1'b0;
      @(negedge clk);
      chk_state("post_rst");
      rd(0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
